sd_host_cmd: RTL
================

// Module: sd_host_cmd
// PURPOSE
//  Host-side SD command-line initiator: generates sd_clk, serialises 48-bit commands (start, dir=1, index, arg, CRC7, end) onto CMD.
//  Receives and CRC-checks R1/R3/R2-style responses.
//  Pairs with sd_phy/sd_link as the opposite protocol end; used as bench stimulus and as host core for loopback FPGA builds.
// PARAMETERS
//  CLK_DIV   2   clk_50 cycles per sd_clk half-period (>=1); sd_clk = clk_50/(2*CLK_DIV)
//  NCR_MAX   64  sd_clk rises allowed after end bit before response start bit; exceeding it = timeout
//  NRC_GAP   8   sd_clk cycles with CMD released after each transaction before done
// PORTS
//  clk_50         in   1    sole clock
//  reset          in   1    synchronous, active-high reset
//  cmd_go         in   1    1-cycle request; sampled only when cmd_busy=0
//  cmd_index      in   6    command index, captured on accepted cmd_go
//  cmd_arg        in   32   argument, captured on accepted cmd_go
//  cmd_resp_type  in   2    0 none, 1 R48+CRC, 2 R136 (R2), 3 R48 no CRC (R3); captured on go
//  cmd_busy       out  1    high from cycle after accept until done pulse
//  cmd_done       out  1    1-cycle pulse, transaction complete
//  cmd_timeout    out  1    valid with done: no start bit within NCR_MAX
//  cmd_crc_err    out  1    valid with done: CRC7 mismatch or end bit 0
//  resp_out       out  136  response, right-aligned (R48 in [47:0], upper bits 0)
//  sd_clk         out  1    card clock, free-running
//  sd_cmd_o       out  1    CMD drive value
//  sd_cmd_t       out  1    1 = CMD released (hi-Z), 0 = driven
//  sd_cmd_i       in   1    CMD pad input
// BEHAVIOUR
//  Reset values:
//   - sd_clk=0, sd_cmd_o=1, sd_cmd_t=1, cmd_busy=0, cmd_done=0, cmd_timeout=0, cmd_crc_err=0, resp_out=0, state=IDLE.
//   - Reset mid-transaction aborts immediately with CMD released; no done pulse.
//  Clock divider:
//   - Counter 0..CLK_DIV-1; sd_clk toggles at wrap.
//   - rise_ev/fall_ev = the clk_50 cycle on which sd_clk goes 1/0.
//   - Host updates CMD only on fall_ev and samples sd_cmd_i only on rise_ev.
//  Handshake:
//   - cmd_go with cmd_busy=0 latches inputs; cmd_busy=1 next cycle.
//   - cmd_go while busy is ignored, with no side effects.
//   - resp_out, cmd_timeout and cmd_crc_err clear on accept and hold after done until the next accept.
//  FSM:
//   - IDLE: on accept -> TX.
//   - TX: first fall_ev drives start bit 0 (sd_cmd_t=0). One bit per fall_ev, MSB first, 48 bits.
//     CRC7 (x^7+x^3+1, seed 0) accumulates over bits 47..8 and is shifted out as bits 7..1; bit 0 = 1.
//   - TX exit: the fall_ev after the end bit sets sd_cmd_t=1, then -> resp_type==0 ? GAP : WAIT.
//   - WAIT: count rise_ev. sd_cmd_i==0 on a rise_ev = start bit -> RX.
//     Count reaching NCR_MAX with no start bit -> cmd_timeout=1, -> GAP.
//   - RX: shift sd_cmd_i in on each rise_ev until 48 (type 1/3) or 136 (type 2) bits, start bit included -> CHK.
//   - CHK (1 cycle): evaluate and set cmd_crc_err, then -> GAP.
//     - type 1: CRC7 over resp[47:8] vs resp[7:1]
//     - type 2: CRC7 over resp[127:8] vs resp[7:1]
//     - type 3: CRC not checked
//     - all types: resp[0]==0 sets err.
//   - GAP: CMD released, count NRC_GAP rise_ev, then cmd_done=1 and cmd_busy=0 on the same cycle -> IDLE.
//  Latency:
//   - accept -> first CMD bit <= 2*CLK_DIV+1 cycles.
//   - no-response command: done exactly (48+NRC_GAP) sd_clk periods after the start bit, +/- divider phase.
//  Widths: bit counter 8 bits (max 136). Ncr counter is sized to hold NCR_MAX.
// STRUCTURE
//  - sd_host_defs.vh: RESP_NONE/R48/R136/R48_NOCRC codes, FSM state encodings, CRC7 polynomial constant.
//  - One sub-module sd_crc7 (serial CRC7: clear, enable, bit in, 7-bit out).
//    One instance serves both TX generation and RX check, cleared on entry to TX and on RX start bit.
// TESTING
//  - CMD0, arg 0, type 0: CMD shows 0x40_0000_0000_95, then released; done with timeout=0, crc_err=0; no WAIT state.
//  - CMD8, arg 0x1AA, type 1; bench returns 0x08_0000_01AA_13 after 5 clks: TX 0x48_0000_01AA_87; resp_out[47:0]=0x08000001AA13, crc_err=0.
//  - Same, bench returns last byte 0x15: crc_err=1. Type 3 with the same bytes: crc_err=0.
//  - Type 1, sd_cmd_i held 1: done after NCR_MAX rises past the end bit, timeout=1, resp_out=0.
//  - Type 2, 136-bit CSD with valid CRC7: resp_out matches all 136 bits, crc_err=0; busy stays high through RX+GAP.
//  - cmd_go pulsed mid-TX: ignored, serial stream unchanged. reset asserted at bit 20: next cycle sd_cmd_t=1, busy=0, no done pulse.

Source files
------------

// File: rtl/sd_host_cmd_pkg.sv
// Shared types and constants for the SD host command-line initiator.
// Response type codes, FSM states and the serial CRC7 step.
package sd_host_cmd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE      = 2'd0,
        RESP_R48       = 2'd1,
        RESP_R136      = 2'd2,
        RESP_R48_NOCRC = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_CHK  = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

    // x^7 + x^3 + 1
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    endfunction

endpackage

// File: rtl/sd_host_cmd_if.sv
// Command request/response handshake between a controller and the SD host core.
interface sd_host_cmd_if;
    import sd_host_cmd_pkg::*;

    logic         cmd_go;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   cmd_resp_type;
    logic         cmd_busy;
    logic         cmd_done;
    logic         cmd_timeout;
    logic         cmd_crc_err;
    logic [135:0] resp_out;

    modport master (
        output cmd_go, cmd_index, cmd_arg, cmd_resp_type,
        input  cmd_busy, cmd_done, cmd_timeout, cmd_crc_err, resp_out
    );

    modport slave (
        input  cmd_go, cmd_index, cmd_arg, cmd_resp_type,
        output cmd_busy, cmd_done, cmd_timeout, cmd_crc_err, resp_out
    );

endinterface

// File: rtl/sd_host_cmd_crc7.sv
// Serial CRC7 accumulator; clear and enable together restart from zero with din included.
module sd_host_cmd_crc7
    import sd_host_cmd_pkg::*;
(
    input  logic       clk_50,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic [6:0] base;

    always_comb begin
        base  = clr_i ? 7'd0 : crc_q;
        crc_d = en_i ? crc7_step(base, din_i) : base;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_host_cmd.sv
// SD host command-line initiator: sd_clk generation, 48-bit command serialiser,
// R1/R3/R2 response receiver with CRC7 check.
//
// state | meaning
// IDLE  | waiting for cmd_go
// TX    | shifting start..end bit onto CMD, one bit per sd_clk fall
// WAIT  | CMD released, counting rises for the response start bit
// RX    | shifting response bits in on sd_clk rise
// CHK   | one cycle to evaluate CRC7 / end bit
// GAP   | CMD released for NRC_GAP rises, then done
module sd_host_cmd
    import sd_host_cmd_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int NCR_MAX = 64,
    parameter int NRC_GAP = 8
) (
    input  logic         clk_50,
    input  logic         reset,
    sd_host_cmd_if.slave cmd,
    output logic         sd_clk,
    output logic         sd_cmd_o,
    output logic         sd_cmd_t,
    input  logic         sd_cmd_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NCR_W = $clog2(NCR_MAX + 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sd_clk_q;
    logic             tick, rise_ev, fall_ev;

    state_e           state_q;
    resp_type_e       rtype_q;
    logic             busy_q, done_q, timeout_q, crc_err_q;
    logic             cmd_o_q, cmd_t_q;
    logic [39:0]      tx_sr_q;
    logic [135:0]     resp_q;
    logic [7:0]       bit_cnt_q;
    logic [NCR_W-1:0] ncr_q;

    logic             accept;
    logic             crc_clr, crc_en, crc_din;
    logic [6:0]       crc_w;
    logic [7:0]       crc_end;
    logic [2:0]       crc_idx;
    logic             tx_bit;
    logic [7:0]       rx_last;
    logic             crc_bad;

    assign tick    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign rise_ev = tick & ~sd_clk_q;
    assign fall_ev = tick & sd_clk_q;

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            div_cnt_q <= '0;
            sd_clk_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            if (tick) begin
                sd_clk_q <= ~sd_clk_q;
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && cmd.cmd_go && !busy_q;

    // Bits 7..1 of the frame come from the CRC, bit 0 is the end bit.
    assign crc_end = {crc_w, 1'b1};
    assign crc_idx = 3'(8'd47 - bit_cnt_q);
    assign tx_bit  = (bit_cnt_q < 8'd40) ? tx_sr_q[39] : crc_end[crc_idx];

    assign rx_last = (rtype_q == RESP_R136) ? 8'd135 : 8'd47;
    assign crc_bad = !resp_q[0] ||
                     ((rtype_q != RESP_R48_NOCRC) && (crc_w != resp_q[7:1]));

    // R2 excludes its leading 8 bits from the CRC; R48 covers from the start bit.
    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = 1'b0;
        case (state_q)
            ST_IDLE: crc_clr = accept;
            ST_TX: begin
                crc_en  = fall_ev && (bit_cnt_q < 8'd40);
                crc_din = tx_sr_q[39];
            end
            ST_WAIT: begin
                if (rise_ev && !sd_cmd_i) begin
                    crc_clr = 1'b1;
                    crc_en  = (rtype_q != RESP_R136);
                end
                crc_din = sd_cmd_i;
            end
            ST_RX: begin
                if (rise_ev) begin
                    crc_en = (rtype_q == RESP_R136) ?
                             ((bit_cnt_q >= 8'd8) && (bit_cnt_q < 8'd128)) :
                             (bit_cnt_q < 8'd40);
                end
                crc_din = sd_cmd_i;
            end
            default: ;
        endcase
    end

    sd_host_cmd_crc7 u_crc7 (
        .clk_50 (clk_50),
        .reset  (reset),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .din_i  (crc_din),
        .crc_o  (crc_w)
    );

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rtype_q   <= RESP_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            cmd_o_q   <= 1'b1;
            cmd_t_q   <= 1'b1;
            tx_sr_q   <= '0;
            resp_q    <= '0;
            bit_cnt_q <= '0;
            ncr_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tx_sr_q   <= {2'b01, cmd.cmd_index, cmd.cmd_arg};
                        rtype_q   <= resp_type_e'(cmd.cmd_resp_type);
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        crc_err_q <= 1'b0;
                        resp_q    <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (fall_ev) begin
                        if (bit_cnt_q == 8'd48) begin
                            cmd_o_q   <= 1'b1;
                            cmd_t_q   <= 1'b1;
                            bit_cnt_q <= '0;
                            ncr_q     <= '0;
                            state_q   <= (rtype_q == RESP_NONE) ? ST_GAP : ST_WAIT;
                        end else begin
                            cmd_o_q   <= tx_bit;
                            cmd_t_q   <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                            if (bit_cnt_q < 8'd40) begin
                                tx_sr_q <= {tx_sr_q[38:0], 1'b0};
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (rise_ev) begin
                        if (!sd_cmd_i) begin
                            resp_q    <= {resp_q[134:0], 1'b0};
                            bit_cnt_q <= 8'd1;
                            state_q   <= ST_RX;
                        end else if (ncr_q == NCR_W'(NCR_MAX - 1)) begin
                            timeout_q <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= ST_GAP;
                        end else begin
                            ncr_q <= ncr_q + 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (rise_ev) begin
                        resp_q    <= {resp_q[134:0], sd_cmd_i};
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                        if (bit_cnt_q == rx_last) begin
                            state_q <= ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    crc_err_q <= crc_bad;
                    bit_cnt_q <= '0;
                    state_q   <= ST_GAP;
                end
                ST_GAP: begin
                    if (rise_ev) begin
                        if (bit_cnt_q == 8'(NRC_GAP - 1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sd_clk          = sd_clk_q;
    assign sd_cmd_o        = cmd_o_q;
    assign sd_cmd_t        = cmd_t_q;
    assign cmd.cmd_busy    = busy_q;
    assign cmd.cmd_done    = done_q;
    assign cmd.cmd_timeout = timeout_q;
    assign cmd.cmd_crc_err = crc_err_q;
    assign cmd.resp_out    = resp_q;

endmodule
